// File: rtl/arf062b064e1r1w0cbbehsaa4acw_rd_pkg.sv
// Shared constants and types for the register-file read port.
package arf062b064e1r1w0cbbehsaa4acw_rd_pkg;

  localparam int ENTRIES  = 62;
  localparam int DWIDTH   = 64;
  localparam int AWIDTH   = 6;
  localparam int OQ_DEPTH = 4;
  localparam int PTR_W    = $clog2(OQ_DEPTH);
  localparam int CNT_W    = $clog2(OQ_DEPTH + 1);

  typedef struct packed {
    logic              err;
    logic [DWIDTH-1:0] data;
  } rd_rsp_t;

  typedef logic [PTR_W-1:0] oq_ptr_t;
  typedef logic [CNT_W-1:0] oq_cnt_t;

endpackage

// File: rtl/arf062b064e1r1w0cbbehsaa4acw_rsp_fifo.sv
// Flop-based response FIFO; the head is read straight from the storage flops.
module arf062b064e1r1w0cbbehsaa4acw_rsp_fifo
  import arf062b064e1r1w0cbbehsaa4acw_rd_pkg::*;
#(
  parameter int DEPTH = OQ_DEPTH
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  rd_rsp_t push_data,
  input  logic    pop,
  output rd_rsp_t head,
  output oq_cnt_t count
);

  rd_rsp_t mem [DEPTH];
  oq_ptr_t wr_ptr;
  oq_ptr_t rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n)
                                   !(push && count == CNT_W'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(pop && count == '0));

endmodule

// File: rtl/arf062b064e1r1w0cbbehsaa4acw_rd_port.sv
// Read port: request handshake, one-cycle array access stage with write
// forwarding and range check, then a credit-limited response queue.
module arf062b064e1r1w0cbbehsaa4acw_rd_port
  import arf062b064e1r1w0cbbehsaa4acw_rd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_vld,
  input  logic [AWIDTH-1:0] rd_req_addr,
  output logic              rd_req_rdy,
  output logic [AWIDTH-1:0] arr_rd_addr,
  input  logic [DWIDTH-1:0] arr_rd_data,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rd_rsp_vld,
  output logic [DWIDTH-1:0] rd_rsp_data,
  output logic              rd_rsp_err,
  input  logic              rd_rsp_rdy
);

  logic              s1_vld;
  logic [AWIDTH-1:0] s1_addr;
  logic              rdy_en;
  logic              accept;
  logic              s1_illegal;
  logic              fwd;
  logic              pop;
  logic [CNT_W:0]    credit_use;
  oq_cnt_t           q_count;
  rd_rsp_t           s1_rsp;
  rd_rsp_t           head;

  // rdy_en keeps the port closed until the first edge after reset release.
  assign credit_use = {1'b0, q_count} + {{CNT_W{1'b0}}, s1_vld};
  assign rd_req_rdy = rdy_en && (credit_use < (CNT_W + 1)'(OQ_DEPTH));
  assign accept     = rd_req_vld && rd_req_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en  <= 1'b0;
      s1_vld  <= 1'b0;
      s1_addr <= '0;
    end else begin
      rdy_en <= 1'b1;
      s1_vld <= accept;
      if (accept) s1_addr <= rd_req_addr;
    end
  end

  assign arr_rd_addr = s1_addr;

  // A write landing this cycle is not yet in the array, so bypass it.
  assign s1_illegal = s1_addr >= AWIDTH'(ENTRIES);
  assign fwd        = wr_en && (wr_addr == s1_addr) && !s1_illegal;

  always_comb begin
    s1_rsp.err  = s1_illegal;
    s1_rsp.data = arr_rd_data;
    if (s1_illegal) s1_rsp.data = '0;
    else if (fwd)   s1_rsp.data = wr_data;
  end

  assign rd_rsp_vld = (q_count != '0);
  assign pop        = rd_rsp_vld && rd_rsp_rdy;

  arf062b064e1r1w0cbbehsaa4acw_rsp_fifo #(.DEPTH(OQ_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_vld),
    .push_data (s1_rsp),
    .pop       (pop),
    .head      (head),
    .count     (q_count)
  );

  assign rd_rsp_data = head.data;
  assign rd_rsp_err  = head.err;

endmodule
